demux_l1a4: RTL and testbench



---
 rtl/demux_l1a4.sv | 116 +++++++++++
 tb/tb_demux_l1a4.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_l1a4.sv
// Purpose: spreads one serial BW-bit word stream round-robin over four lanes and publishes them as aligned groups.
// Latency: a full group is published on the edge that captures its lane-3 word; a partial group is flushed after FLUSH_CYC idle cycles.
// Backpressure: none; every valid word is accepted, and outputs hold the last published group until the next publish.
module demux_l1a4 #(
    parameter int BW        = 8,
    parameter int FLUSH_CYC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] Entrada,
    input  logic          validEntrada,
    output logic [BW-1:0] Salida0,
    output logic [BW-1:0] Salida1,
    output logic [BW-1:0] Salida2,
    output logic [BW-1:0] Salida3,
    output logic          validSalida0,
    output logic          validSalida1,
    output logic          validSalida2,
    output logic          validSalida3,
    output logic          grupo_listo,
    output logic [1:0]    lane_ptr
);

    // Idle counter: just wide enough to reach FLUSH_CYC, at least one bit.
    localparam int CW = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
    // The flush fires on the idle edge where the counter already shows FLUSH_CYC-1.
    localparam logic [CW-1:0] IDLE_LAST = (FLUSH_CYC > 0) ? CW'(FLUSH_CYC - 1) : '0;
    localparam logic [CW-1:0] IDLE_MAX  = '1;

    typedef enum logic {
        VACIO    = 1'b0,
        LLENANDO = 1'b1
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_stg [4];
    logic [3:0]      r_stg_vld;
    logic [1:0]      r_lane_ptr;
    logic [CW-1:0]   r_idle;
    logic [BW-1:0]   r_sal [4];
    logic [3:0]      r_vsal;
    logic            r_grupo;

    logic            w_publish_full;
    logic            w_flush;
    logic            w_flush_en;

    assign w_flush_en     = (FLUSH_CYC > 0);
    // Lane-3 word arriving completes the group; it bypasses staging.
    assign w_publish_full = validEntrada && (r_lane_ptr == 2'd3);
    // An arriving word always beats the idle limit.
    assign w_flush        = w_flush_en && !validEntrada && (r_state == LLENANDO) &&
                            (r_idle == IDLE_LAST);

    // Staging, lane pointer, idle counter, FSM and registered group outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= VACIO;
            r_stg_vld  <= '0;
            r_lane_ptr <= '0;
            r_idle     <= '0;
            r_vsal     <= '0;
            r_grupo    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_stg[i] <= '0;
                r_sal[i] <= '0;
            end
        end else begin
            r_grupo <= w_publish_full || w_flush;
            if (validEntrada) begin
                r_idle <= '0;
                if (r_lane_ptr == 2'd3) begin
                    r_sal[0]   <= r_stg[0];
                    r_sal[1]   <= r_stg[1];
                    r_sal[2]   <= r_stg[2];
                    r_sal[3]   <= Entrada;
                    r_vsal     <= 4'hF;
                    r_stg_vld  <= '0;
                    r_lane_ptr <= '0;
                    r_state    <= VACIO;
                end else begin
                    r_stg[r_lane_ptr]     <= Entrada;
                    r_stg_vld[r_lane_ptr] <= 1'b1;
                    r_lane_ptr            <= r_lane_ptr + 2'd1;
                    r_state               <= LLENANDO;
                end
            end else if (r_state == LLENANDO) begin
                if (w_flush) begin
                    // Unfilled lanes publish zero with their valid low.
                    for (int i = 0; i < 4; i++) begin
                        r_sal[i] <= r_stg_vld[i] ? r_stg[i] : '0;
                    end
                    r_vsal     <= r_stg_vld;
                    r_stg_vld  <= '0;
                    r_lane_ptr <= '0;
                    r_idle     <= '0;
                    r_state    <= VACIO;
                end else if (r_idle != IDLE_MAX) begin
                    r_idle <= r_idle + 1'b1;
                end
            end
        end
    end

    assign Salida0      = r_sal[0];
    assign Salida1      = r_sal[1];
    assign Salida2      = r_sal[2];
    assign Salida3      = r_sal[3];
    assign validSalida0 = r_vsal[0];
    assign validSalida1 = r_vsal[1];
    assign validSalida2 = r_vsal[2];
    assign validSalida3 = r_vsal[3];
    assign grupo_listo  = r_grupo;
    assign lane_ptr     = r_lane_ptr;

endmodule

// File: tb/tb_demux_l1a4.sv
// Bench for demux_l1a4: one instance with FLUSH_CYC=4 and one with FLUSH_CYC=0 share the same input stream.
// Directed scenarios are followed by randomized traffic; a word-level model predicts every output each cycle.
// Outputs are sampled 1 time unit after the rising edge; inputs change only then.
module tb_demux_l1a4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Entrada;
    logic       validEntrada;

    always #5 clk = ~clk;

    logic [7:0] a_s0, a_s1, a_s2, a_s3, b_s0, b_s1, b_s2, b_s3;
    logic       a_v0, a_v1, a_v2, a_v3, b_v0, b_v1, b_v2, b_v3;
    logic       a_gl, b_gl;
    logic [1:0] a_ptr, b_ptr;

    demux_l1a4 #(.BW(8), .FLUSH_CYC(4)) dut_f4 (
        .clk(clk), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
        .Salida0(a_s0), .Salida1(a_s1), .Salida2(a_s2), .Salida3(a_s3),
        .validSalida0(a_v0), .validSalida1(a_v1), .validSalida2(a_v2), .validSalida3(a_v3),
        .grupo_listo(a_gl), .lane_ptr(a_ptr)
    );

    demux_l1a4 #(.BW(8), .FLUSH_CYC(0)) dut_f0 (
        .clk(clk), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
        .Salida0(b_s0), .Salida1(b_s1), .Salida2(b_s2), .Salida3(b_s3),
        .validSalida0(b_v0), .validSalida1(b_v1), .validSalida2(b_v2), .validSalida3(b_v3),
        .grupo_listo(b_gl), .lane_ptr(b_ptr)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: a list of pending words plus a count of idle cycles.
    int         m_flush [2] = '{4, 0};
    logic [7:0] m_words [2][$];
    int         m_idle  [2];
    logic [7:0] m_sal   [2][4];
    logic [3:0] m_vs    [2];
    logic       m_gl    [2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_words[k].delete();
            m_idle[k] = 0;
            m_vs[k]   = 4'h0;
            m_gl[k]   = 1'b0;
            for (int i = 0; i < 4; i++) m_sal[k][i] = 8'h00;
        end
    endfunction

    function automatic void model_publish(int k);
        int n;
        n = m_words[k].size();
        for (int i = 0; i < 4; i++) begin
            m_sal[k][i] = (i < n) ? m_words[k][i] : 8'h00;
            m_vs[k][i]  = (i < n);
        end
        m_words[k].delete();
        m_idle[k] = 0;
        m_gl[k]   = 1'b1;
    endfunction

    function automatic void model_step(logic v, logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            m_gl[k] = 1'b0;
            if (v) begin
                m_words[k].push_back(d);
                m_idle[k] = 0;
                if (m_words[k].size() == 4) model_publish(k);
            end else if (m_words[k].size() > 0) begin
                m_idle[k]++;
                if (m_flush[k] > 0 && m_idle[k] == m_flush[k]) model_publish(k);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string step);
        logic [7:0] os [4];
        logic [3:0] ov;
        logic       ogl;
        logic [1:0] optr;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                os = '{a_s0, a_s1, a_s2, a_s3};
                ov = {a_v3, a_v2, a_v1, a_v0};
                ogl = a_gl;
                optr = a_ptr;
            end else begin
                os = '{b_s0, b_s1, b_s2, b_s3};
                ov = {b_v3, b_v2, b_v1, b_v0};
                ogl = b_gl;
                optr = b_ptr;
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s/F%0d/Salida%0d", step, m_flush[k], i), os[i], m_sal[k][i]);
            chk($sformatf("%s/F%0d/validSalida", step, m_flush[k]), {4'h0, ov}, {4'h0, m_vs[k]});
            chk($sformatf("%s/F%0d/grupo_listo", step, m_flush[k]), {7'h0, ogl}, {7'h0, m_gl[k]});
            chk($sformatf("%s/F%0d/lane_ptr", step, m_flush[k]), {6'h0, optr},
                8'(m_words[k].size()));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then compare.
    task automatic cycle(input logic v, input logic [7:0] d, input string step);
        validEntrada = v;
        Entrada      = v ? d : 8'($urandom);
        @(posedge clk);
        model_step(v, d);
        #1;
        check_all(step);
    endtask

    task automatic idle(input int n, input string step);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, step);
    endtask

    // Reset asserted between edges: outputs must clear before the next edge.
    task automatic async_reset(input string step);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all({step, "/async"});
        @(posedge clk);
        #1;
        check_all({step, "/held"});
        reset = 1'b0;
    endtask

    initial begin
        int p;
        reset        = 1'b1;
        validEntrada = 1'b0;
        Entrada      = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Full group, strobe one cycle later.
        cycle(1'b1, 8'hA0, "grpA");
        cycle(1'b1, 8'hA1, "grpA");
        cycle(1'b1, 8'hA2, "grpA");
        cycle(1'b1, 8'hA3, "grpA");
        cycle(1'b0, 8'h00, "grpA_after");
        cycle(1'b0, 8'h00, "grpA_after");

        // Short gap below the flush limit.
        cycle(1'b1, 8'h11, "gap");
        cycle(1'b1, 8'h22, "gap");
        idle(2, "gap_idle");
        cycle(1'b1, 8'h33, "gap");
        cycle(1'b1, 8'h44, "gap");

        // Partial flush after four idle cycles, then next word in lane 0.
        cycle(1'b1, 8'h55, "flush");
        cycle(1'b1, 8'h66, "flush");
        idle(4, "flush_idle");
        cycle(1'b1, 8'h77, "after_flush");

        // Word arriving on the edge the idle limit would be reached.
        cycle(1'b1, 8'h78, "race");
        idle(3, "race_idle");
        cycle(1'b1, 8'h79, "race_word");
        idle(2, "race_idle2");
        cycle(1'b1, 8'h7A, "race_done");

        // Back-to-back groups.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), "b2b");
        idle(3, "b2b_idle");

        // Mid-group reset discards the partial group.
        cycle(1'b1, 8'h81, "rst_mid");
        cycle(1'b1, 8'h82, "rst_mid");
        cycle(1'b1, 8'h83, "rst_mid");
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h91 + i), "post_rst");

        // Long idle with a single staged word: only the FLUSH_CYC=4 instance flushes.
        cycle(1'b1, 8'hC1, "noflush");
        idle(20, "noflush_idle");
        cycle(1'b1, 8'hC2, "noflush");
        cycle(1'b1, 8'hC3, "noflush");
        cycle(1'b1, 8'hC4, "noflush");
        idle(2, "noflush_end");

        // Randomized traffic with varying density and occasional resets.
        p = 90;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       p = 90;
                    1:       p = 50;
                    default: p = 12;
                endcase
            end
            if ($urandom_range(0, 199) == 0) async_reset("rand");
            cycle($urandom_range(0, 99) < p, 8'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
